// File: rtl/key_sw_device_if.sv
// rtl/key_sw_device_if.sv - processor data bus as seen by the KEY/SW responder
//
// abus   : bus address from the MEM stage
// wbus   : bus write data
// we     : write strobe, sampled at posedge clk
// re     : read strobe, read side effects apply at posedge clk
// rbus   : read data, combinational from abus and device state
// devsel : high when abus hits one of the device registers
interface key_sw_device_if #(
    parameter int DBITS = 32
);
    logic [DBITS-1:0] abus;
    logic [DBITS-1:0] wbus;
    logic             we;
    logic             re;
    logic [DBITS-1:0] rbus;
    logic             devsel;

    modport master (output abus, output wbus, output we, output re, input rbus, input devsel);
    modport slave  (input abus, input wbus, input we, input re, output rbus, output devsel);
endinterface

// File: rtl/key_sw_device.sv
// rtl/key_sw_device.sv - memory-mapped KEY/SW responder with debounce, status and interrupt
//
// clk     : system clock
// RESET_N : asynchronous active-low reset
// bus     : slave side of the processor data bus (address, write data, strobes, read data, devsel)
// KEY     : raw pushbuttons, active-low, asynchronous
// SW      : raw slide switches, active-high, asynchronous
// INTR    : registered interrupt request, (kready & kIE) | (sready & sIE)
//
// Registers: KDATA @ BASEKEY, KCTRL @ BASEKEY+4, SDATA @ BASESW, SCTRL @ BASESW+4.
// CTRL layout: bit0 ready (RO), bit2 overrun (write 0 clears), bit8 interrupt enable.
module key_sw_device #(
    parameter int               DBITS     = 32,
    parameter int               KEYBITS   = 4,
    parameter int               SWBITS    = 10,
    parameter logic [DBITS-1:0] BASEKEY   = 32'hFFFFF080,
    parameter logic [DBITS-1:0] BASESW    = 32'hFFFFF090,
    parameter int               DEBCYCLES = 500000,
    parameter int               CNTBITS   = 20
) (
    input  logic               clk,
    input  logic               RESET_N,
    key_sw_device_if.slave     bus,
    input  logic [KEYBITS-1:0] KEY,
    input  logic [SWBITS-1:0]  SW,
    output logic               INTR
);
    localparam logic [DBITS-1:0]   KDATA_A  = BASEKEY;
    localparam logic [DBITS-1:0]   KCTRL_A  = BASEKEY + DBITS'(4);
    localparam logic [DBITS-1:0]   SDATA_A  = BASESW;
    localparam logic [DBITS-1:0]   SCTRL_A  = BASESW + DBITS'(4);
    localparam logic [CNTBITS-1:0] CNT_LAST = CNTBITS'(DEBCYCLES - 1);

    logic [KEYBITS-1:0] k_meta, k_syn, k_stable;
    logic [SWBITS-1:0]  s_meta, s_syn, s_stable;
    logic [CNTBITS-1:0] k_cnt, s_cnt;
    logic               k_ready, k_over, k_ie;
    logic               s_ready, s_over, s_ie;
    logic               k_event, s_event;
    logic               hit_kdata, hit_kctrl, hit_sdata, hit_sctrl;

    assign hit_kdata  = (bus.abus == KDATA_A);
    assign hit_kctrl  = (bus.abus == KCTRL_A);
    assign hit_sdata  = (bus.abus == SDATA_A);
    assign hit_sctrl  = (bus.abus == SCTRL_A);
    assign bus.devsel = hit_kdata | hit_kctrl | hit_sdata | hit_sctrl;

    // The change event is the edge on which the counter has seen the
    // syn/stable mismatch for DEBCYCLES consecutive cycles.
    assign k_event = (k_syn != k_stable) && (k_cnt == CNT_LAST);
    assign s_event = (s_syn != s_stable) && (s_cnt == CNT_LAST);

    // Two-flop synchronisers; KEY is inverted first so pressed reads as 1.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            k_meta <= '0;
            k_syn  <= '0;
            s_meta <= '0;
            s_syn  <= '0;
        end else begin
            k_meta <= ~KEY;
            k_syn  <= k_meta;
            s_meta <= SW;
            s_syn  <= s_meta;
        end
    end

    // Whole-vector debounce: any return to the stable value restarts the count.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            k_cnt    <= '0;
            k_stable <= '0;
            s_cnt    <= '0;
            s_stable <= '0;
        end else begin
            if (k_syn == k_stable) begin
                k_cnt <= '0;
            end else if (k_cnt == CNT_LAST) begin
                k_stable <= k_syn;
                k_cnt    <= '0;
            end else begin
                k_cnt <= k_cnt + 1'b1;
            end

            if (s_syn == s_stable) begin
                s_cnt <= '0;
            end else if (s_cnt == CNT_LAST) begin
                s_stable <= s_syn;
                s_cnt    <= '0;
            end else begin
                s_cnt <= s_cnt + 1'b1;
            end
        end
    end

    // Status: a change event beats a same-edge data read, and an overrun
    // set beats a same-edge overrun clear.
    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            k_ready <= 1'b0;
            k_over  <= 1'b0;
            k_ie    <= 1'b0;
            s_ready <= 1'b0;
            s_over  <= 1'b0;
            s_ie    <= 1'b0;
            INTR    <= 1'b0;
        end else begin
            if (k_event)                      k_ready <= 1'b1;
            else if (bus.re && hit_kdata)     k_ready <= 1'b0;
            if (k_event && k_ready)           k_over  <= 1'b1;
            else if (bus.we && hit_kctrl && !bus.wbus[2]) k_over <= 1'b0;
            if (bus.we && hit_kctrl)          k_ie    <= bus.wbus[8];

            if (s_event)                      s_ready <= 1'b1;
            else if (bus.re && hit_sdata)     s_ready <= 1'b0;
            if (s_event && s_ready)           s_over  <= 1'b1;
            else if (bus.we && hit_sctrl && !bus.wbus[2]) s_over <= 1'b0;
            if (bus.we && hit_sctrl)          s_ie    <= bus.wbus[8];

            INTR <= (k_ready & k_ie) | (s_ready & s_ie);
        end
    end

    always_comb begin
        bus.rbus = '0;
        if (hit_kdata) begin
            bus.rbus[KEYBITS-1:0] = k_stable;
        end else if (hit_kctrl) begin
            bus.rbus[0] = k_ready;
            bus.rbus[2] = k_over;
            bus.rbus[8] = k_ie;
        end else if (hit_sdata) begin
            bus.rbus[SWBITS-1:0] = s_stable;
        end else if (hit_sctrl) begin
            bus.rbus[0] = s_ready;
            bus.rbus[2] = s_over;
            bus.rbus[8] = s_ie;
        end
    end
endmodule

// File: tb/tb_key_sw_device.sv
// tb/tb_key_sw_device.sv - self-checking bench for key_sw_device
module tb_key_sw_device;
    localparam int DEB = 4;
    localparam logic [31:0] KD = 32'hFFFFF080;
    localparam logic [31:0] KC = 32'hFFFFF084;
    localparam logic [31:0] SD = 32'hFFFFF090;
    localparam logic [31:0] SC = 32'hFFFFF094;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] key;
    logic [9:0] sw;
    logic       intr;
    int         total = 0;
    int         bad = 0;

    key_sw_device_if #(.DBITS(32)) bus_i ();

    key_sw_device #(.DEBCYCLES(DEB), .CNTBITS(3)) dut (
        .clk     (clk),
        .RESET_N (rst_n),
        .bus     (bus_i),
        .KEY     (key),
        .SW      (sw),
        .INTR    (intr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        we;
        logic        re;
        logic [31:0] exp_rbus;
        logic        exp_devsel;
    } vec_t;

    vec_t vecs[18];

    // Reference model state
    logic [3:0] m_ks;
    logic [9:0] m_ss;
    int         m_krun, m_srun;
    bit         m_kr, m_ko, m_kie, m_sr, m_so, m_sie, m_intr;
    logic [3:0] kq[$];
    logic [9:0] sq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string name);
        bus_i.abus = a;
        bus_i.we   = 1'b0;
        bus_i.re   = 1'b0;
        #1;
        chk(name, bus_i.rbus, exp);
    endtask

    task automatic op(input logic [31:0] a, input logic [31:0] wd, input logic w, input logic r);
        bus_i.abus  = a;
        bus_i.wbus  = wd;
        bus_i.we    = w;
        bus_i.re    = r;
        @(negedge clk);
        bus_i.we = 1'b0;
        bus_i.re = 1'b0;
    endtask

    task automatic m_reset();
        m_ks = '0; m_ss = '0; m_krun = 0; m_srun = 0;
        m_kr = 0; m_ko = 0; m_kie = 0; m_sr = 0; m_so = 0; m_sie = 0; m_intr = 0;
        kq = '{4'h0, 4'h0};
        sq = '{10'h0, 10'h0};
    endtask

    function automatic logic [31:0] m_rbus(input logic [31:0] a);
        if (a == KD) return {28'h0, m_ks};
        if (a == KC) return {23'h0, m_kie, 5'h0, m_ko, 1'b0, m_kr};
        if (a == SD) return {22'h0, m_ss};
        if (a == SC) return {23'h0, m_sie, 5'h0, m_so, 1'b0, m_sr};
        return 32'h0;
    endfunction

    // One clock edge of the device, derived from the register-level rules:
    // syn is the input seen two edges earlier, and the stable value takes a
    // new syn once it has differed for DEB consecutive edges.
    task automatic m_step(input logic [31:0] a, input logic [31:0] wd, input logic w, input logic r,
                          input logic [3:0] kin, input logic [9:0] sin);
        logic [3:0] ksyn;
        logic [9:0] ssyn;
        bit kev, sev, kr0, sr0;
        ksyn = kq.pop_front();
        kq.push_back(~kin);
        ssyn = sq.pop_front();
        sq.push_back(sin);
        kev = 0;
        sev = 0;
        m_intr = (m_kr && m_kie) || (m_sr && m_sie);
        if (ksyn != m_ks) begin
            m_krun++;
            if (m_krun == DEB) begin kev = 1; m_ks = ksyn; m_krun = 0; end
        end else m_krun = 0;
        if (ssyn != m_ss) begin
            m_srun++;
            if (m_srun == DEB) begin sev = 1; m_ss = ssyn; m_srun = 0; end
        end else m_srun = 0;
        kr0 = m_kr;
        sr0 = m_sr;
        if (kev) begin if (kr0) m_ko = 1; m_kr = 1; end
        else if (r && a == KD) m_kr = 0;
        if (sev) begin if (sr0) m_so = 1; m_sr = 1; end
        else if (r && a == SD) m_sr = 0;
        if (w && a == KC) begin m_kie = wd[8]; if (!wd[2] && !(kev && kr0)) m_ko = 0; end
        if (w && a == SC) begin m_sie = wd[8]; if (!wd[2] && !(sev && sr0)) m_so = 0; end
    endtask

    initial begin
        logic [31:0] ra;
        vecs[0]  = '{KD, 32'h0, 0, 1, 32'h0, 1};
        vecs[1]  = '{KC, 32'h0, 0, 1, 32'h0, 1};
        vecs[2]  = '{SD, 32'h0, 0, 1, 32'h0, 1};
        vecs[3]  = '{SC, 32'h0, 0, 1, 32'h0, 1};
        vecs[4]  = '{32'hFFFFF0A0, 32'h100, 1, 1, 32'h0, 0};
        vecs[5]  = '{32'hFFFFF088, 32'h0, 0, 1, 32'h0, 0};
        vecs[6]  = '{32'hFFFFF098, 32'h0, 0, 1, 32'h0, 0};
        vecs[7]  = '{32'h7FFFF080, 32'h0, 0, 1, 32'h0, 0};
        vecs[8]  = '{KC, 32'hFFFFFFFF, 1, 0, 32'h0, 1};
        vecs[9]  = '{KC, 32'h0, 0, 0, 32'h100, 1};
        vecs[10] = '{SC, 32'h104, 1, 0, 32'h0, 1};
        vecs[11] = '{SC, 32'h0, 0, 0, 32'h100, 1};
        vecs[12] = '{SD, 32'hFFFFFFFF, 1, 0, 32'h0, 1};
        vecs[13] = '{SD, 32'h0, 0, 0, 32'h0, 1};
        vecs[14] = '{KC, 32'h0, 1, 0, 32'h100, 1};
        vecs[15] = '{KC, 32'h0, 0, 0, 32'h0, 1};
        vecs[16] = '{SC, 32'h0, 1, 0, 32'h100, 1};
        vecs[17] = '{SC, 32'h0, 0, 0, 32'h0, 1};

        rst_n = 1'b0;
        key = 4'hF;
        sw = 10'h0;
        bus_i.abus = 32'h0;
        bus_i.wbus = 32'h0;
        bus_i.we = 1'b0;
        bus_i.re = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        chk("reset_intr", {31'h0, intr}, 32'h0);

        // Register map, decode and reset values
        for (int i = 0; i < 18; i++) begin
            bus_i.abus = vecs[i].addr;
            bus_i.wbus = vecs[i].wdata;
            bus_i.we   = vecs[i].we;
            bus_i.re   = vecs[i].re;
            #1;
            chk($sformatf("vec%0d_rbus", i), bus_i.rbus, vecs[i].exp_rbus);
            chk($sformatf("vec%0d_devsel", i), {31'h0, bus_i.devsel}, {31'h0, vecs[i].exp_devsel});
            chk($sformatf("vec%0d_intr", i), {31'h0, intr}, 32'h0);
            @(negedge clk);
            bus_i.we = 1'b0;
            bus_i.re = 1'b0;
        end

        // KEY[1] press: visible on the sixth edge, then a data read clears ready
        key = 4'hD;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            rd(KD, (e == 6) ? 32'h2 : 32'h0, $sformatf("key1_kdata_e%0d", e));
            rd(KC, (e == 6) ? 32'h1 : 32'h0, $sformatf("key1_kctrl_e%0d", e));
        end
        bus_i.abus = KD;
        bus_i.re = 1'b1;
        #1;
        chk("key1_read_val", bus_i.rbus, 32'h2);
        @(negedge clk);
        bus_i.re = 1'b0;
        rd(KC, 32'h0, "key1_ready_clr");

        // SW[0] bounce 1,0,1 then hold at 1
        sw = 10'h1; repeat (2) @(negedge clk);
        sw = 10'h0; repeat (2) @(negedge clk);
        sw = 10'h1;
        for (int e = 1; e <= 6; e++) begin
            @(negedge clk);
            rd(SD, (e == 6) ? 32'h1 : 32'h0, $sformatf("bounce_sdata_e%0d", e));
            rd(SC, (e == 6) ? 32'h1 : 32'h0, $sformatf("bounce_sctrl_e%0d", e));
        end

        // Second SW change without a read sets overrun
        sw = 10'h3;
        repeat (6) @(negedge clk);
        rd(SD, 32'h3, "ovr_sdata");
        rd(SC, 32'h5, "ovr_sctrl");
        op(SC, 32'h0, 1, 0);
        rd(SC, 32'h1, "ovr_cleared");
        op(SD, 32'h0, 0, 1);
        rd(SC, 32'h0, "ovr_ready_clr");

        // Interrupt follows ready by one edge and drops one edge after the read
        op(KC, 32'h100, 1, 0);
        key = 4'hC;
        repeat (6) @(negedge clk);
        rd(KC, 32'h101, "irq_kctrl");
        chk("irq_intr_lag", {31'h0, intr}, 32'h0);
        @(negedge clk);
        chk("irq_intr_set", {31'h0, intr}, 32'h1);
        op(KD, 32'h0, 0, 1);
        chk("irq_intr_hold", {31'h0, intr}, 32'h1);
        @(negedge clk);
        chk("irq_intr_clr", {31'h0, intr}, 32'h0);
        op(KC, 32'h0, 1, 0);

        // Data read on the same edge as a change event
        sw = 10'h7;
        repeat (5) @(negedge clk);
        bus_i.abus = SD;
        bus_i.re = 1'b1;
        #1;
        chk("race_old_val", bus_i.rbus, 32'h3);
        @(negedge clk);
        bus_i.re = 1'b0;
        rd(SD, 32'h7, "race_new_val");
        rd(SC, 32'h1, "race_ready_kept");
        rd(32'hFFFFF0A0, 32'h0, "miss_rbus");
        chk("miss_devsel", {31'h0, bus_i.devsel}, 32'h0);

        // Reset in the middle of a debounce count
        sw = 10'h0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        rd(SD, 32'h0, "async_rst_sdata");
        rd(SC, 32'h0, "async_rst_sctrl");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        rd(SD, 32'h0, "rst_mid_sdata");
        rd(SC, 32'h0, "rst_mid_sctrl");

        // Randomised run against the reference model
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(9) == 0) key = 4'($urandom);
            if ($urandom_range(9) == 0) sw = 10'($urandom);
            case ($urandom_range(4))
                0: ra = KD;
                1: ra = KC;
                2: ra = SD;
                3: ra = SC;
                default: ra = ($urandom_range(1) == 0) ? 32'hFFFFF0A0 : $urandom;
            endcase
            bus_i.abus = ra;
            bus_i.wbus = $urandom;
            bus_i.we = ($urandom_range(3) == 0);
            bus_i.re = ($urandom_range(2) == 0);
            #1;
            chk($sformatf("rnd%0d_rbus", c), bus_i.rbus, m_rbus(ra));
            chk($sformatf("rnd%0d_devsel", c), {31'h0, bus_i.devsel},
                {31'h0, (ra == KD || ra == KC || ra == SD || ra == SC)});
            chk($sformatf("rnd%0d_intr", c), {31'h0, intr}, {31'h0, m_intr});
            m_step(ra, bus_i.wbus, bus_i.we, bus_i.re, key, sw);
            @(negedge clk);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
